// File: rtl/fetch_prefetch_unit.sv
`timescale 1ns/1ps
// Instruction-fetch stage: one-outstanding request port to program memory, prefetch queue
// toward decode, redirect flush and sticky end-of-program halt.
module fetch_prefetch_unit #(
  parameter int                          INSTR_ADDR_WIDTH = 10,
  parameter int                          DATA_WIDTH       = 32,
  parameter int                          QUEUE_DEPTH      = 4,
  parameter logic [INSTR_ADDR_WIDTH-1:0] RESET_PC         = '0,
  parameter logic [INSTR_ADDR_WIDTH-1:0] END_ADDR         = '1
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        imem_req,
  output logic [INSTR_ADDR_WIDTH-1:0] imem_addr,
  input  logic                        imem_ready,
  input  logic                        imem_rvalid,
  input  logic [DATA_WIDTH-1:0]       imem_rdata,
  input  logic                        redirect,
  input  logic [INSTR_ADDR_WIDTH-1:0] redirect_pc,
  output logic                        instr_valid,
  output logic [DATA_WIDTH-1:0]       instr,
  output logic [INSTR_ADDR_WIDTH-1:0] instr_pc,
  output logic [INSTR_ADDR_WIDTH-1:0] instr_pc_plus,
  input  logic                        instr_ready,
  output logic                        pc_end
);

  localparam int IAW = INSTR_ADDR_WIDTH;
  localparam int PW  = $clog2(QUEUE_DEPTH);
  localparam int CW  = PW + 1;

  typedef enum logic [1:0] {START, FETCH, HALT} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [IAW-1:0]        pc;
  } entry_t;

  state_t         state_q, state_d;
  logic [IAW-1:0] fetch_pc;
  logic [IAW-1:0] req_pc;
  logic           inflight;
  entry_t         queue [QUEUE_DEPTH];
  entry_t         head;
  logic [PW-1:0]  rd_ptr, wr_ptr;
  logic [CW-1:0]  count;
  logic [CW:0]    credit_used;

  logic accept, redirect_act, push, pop, end_hit;

  // Redirect is ignored only while leaving reset; everywhere else it outranks pop/push/end.
  assign redirect_act = redirect & (state_q != START);
  assign accept       = imem_req & imem_ready;
  assign push         = imem_rvalid & inflight & (state_q == FETCH) & ~redirect_act;
  assign pop          = instr_valid & instr_ready & ~redirect_act;
  assign head         = queue[rd_ptr];
  assign end_hit      = pop & (head.pc == END_ADDR);
  assign credit_used  = {1'b0, count} + (CW+1)'(inflight);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= START;
    else      state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      START:   state_d = FETCH;
      FETCH:   if (!redirect_act && end_hit) state_d = HALT;
      HALT:    if (redirect_act) state_d = FETCH;
      default: state_d = START;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    if (state_q == FETCH && !redirect && credit_used < (CW+1)'(QUEUE_DEPTH)) imem_req = 1'b1;
  end

  assign imem_addr     = fetch_pc;
  assign instr_valid   = (count != '0);
  assign instr         = instr_valid ? head.data : '0;
  assign instr_pc      = instr_valid ? head.pc : '0;
  assign instr_pc_plus = instr_pc + IAW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      pc_end   <= 1'b0;
    end else if (redirect_act) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      pc_end   <= 1'b0;
    end else begin
      inflight <= accept;
      if (accept) begin
        fetch_pc <= fetch_pc + IAW'(1);
        req_pc   <= fetch_pc;
      end
      if (end_hit) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        pc_end <= 1'b1;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (pop && !push) count <= count - CW'(1);
      end
    end
  end

  // NOTE: queue storage has no reset; outputs are gated by instr_valid so stale contents never leak.
  always_ff @(posedge clk) begin
    if (push) queue[wr_ptr] <= '{data: imem_rdata, pc: req_pc};
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
`timescale 1ns/1ps
// Randomised scoreboard bench for fetch_prefetch_unit: expected pop stream is the PC sequence
// from the last redirect/reset up to END_ADDR, with memory contents derived from the address.
module tb_fetch_prefetch_unit;

  localparam int             IAW = 10;
  localparam int             DW  = 32;
  localparam int             QD  = 4;
  localparam logic [IAW-1:0] END = 10'h005;

  logic           clk, rst_n;
  logic           imem_req, imem_ready, imem_rvalid;
  logic [IAW-1:0] imem_addr;
  logic [DW-1:0]  imem_rdata;
  logic           redirect;
  logic [IAW-1:0] redirect_pc;
  logic           instr_valid, instr_ready, pc_end;
  logic [DW-1:0]  instr;
  logic [IAW-1:0] instr_pc, instr_pc_plus;

  fetch_prefetch_unit #(
    .INSTR_ADDR_WIDTH(IAW), .DATA_WIDTH(DW), .QUEUE_DEPTH(QD),
    .RESET_PC(10'h000), .END_ADDR(END)
  ) dut (
    .clk(clk), .rst(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_pc_plus(instr_pc_plus), .instr_ready(instr_ready), .pc_end(pc_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int pops     = 0;
  bit rand_mem = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [IAW-1:0] a);
    return {6'h2A, a, ~a, 6'h15};
  endfunction

  // Expected pop stream: consecutive PCs from the restart point, ending with END.
  logic [IAW-1:0] exp_q[$];
  logic [IAW-1:0] gen_pc;
  bit             gen_done;

  function automatic void sb_refill();
    while (exp_q.size() < 8 && !gen_done) begin
      exp_q.push_back(gen_pc);
      if (gen_pc == END) gen_done = 1;
      gen_pc = gen_pc + 10'd1;
    end
  endfunction

  function automatic void sb_restart(input logic [IAW-1:0] pc);
    exp_q.delete();
    gen_pc   = pc;
    gen_done = 0;
    sb_refill();
  endfunction

  // Program memory: one response exactly one cycle after each accept.
  initial begin
    logic           acc;
    logic [IAW-1:0] a;
    imem_ready  = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      acc = imem_req & imem_ready;
      a   = imem_addr;
      @(posedge clk);
      #1;
      imem_rvalid = acc;
      imem_rdata  = acc ? mem_word(a) : DW'($urandom);
      imem_ready  = rand_mem ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Monitor: pops against the scoreboard, pc_end timing, hold stability, credit bound.
  initial begin
    bit             end_exp, prev_hold;
    int             outstanding;
    logic [IAW-1:0] prev_pc, e, ep1;
    logic [DW-1:0]  prev_instr;
    end_exp = 0; prev_hold = 0; outstanding = 0; prev_pc = '0; prev_instr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        end_exp = 0; outstanding = 0; prev_hold = 0;
      end else begin
        check("pc_end", pc_end, end_exp);
        if (end_exp) begin
          check("halt_imem_req", imem_req, 0);
          check("halt_instr_valid", instr_valid, 0);
        end
        if (prev_hold) begin
          check("hold_valid", instr_valid, 1);
          check("hold_pc", instr_pc, prev_pc);
          check("hold_instr", instr, prev_instr);
        end
        if (redirect) begin
          outstanding = 0;
          end_exp     = 0;
        end else begin
          if (imem_req && imem_ready) begin
            outstanding++;
            check("credit_bound", outstanding <= QD + 1, 1);
          end
          if (instr_valid && instr_ready) begin
            outstanding--;
            if (exp_q.size() == 0) begin
              fail_now("unexpected_pop", $sformatf("popped pc 0x%0h, expected none", instr_pc));
            end else begin
              e   = exp_q.pop_front();
              ep1 = e + 10'd1;
              check("pop_pc", instr_pc, e);
              check("pop_instr", instr, mem_word(e));
              check("pop_pc_plus", instr_pc_plus, ep1);
              if (e == END) end_exp = 1;
              pops++;
              sb_refill();
            end
          end
        end
        prev_hold  = instr_valid & ~instr_ready & ~redirect;
        prev_pc    = instr_pc;
        prev_instr = instr;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_redirect(input logic [IAW-1:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    sb_restart(pc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_req"}, imem_req, 0);
    check({tag, "_imem_addr"}, imem_addr, 0);
    check({tag, "_instr_valid"}, instr_valid, 0);
    check({tag, "_instr"}, instr, 0);
    check({tag, "_instr_pc"}, instr_pc, 0);
    check({tag, "_instr_pc_plus"}, instr_pc_plus, 1);
    check({tag, "_pc_end"}, pc_end, 0);
  endtask

  task automatic startup_sequence(input string tag);
    @(negedge clk);
    check({tag, "_c1_req"}, imem_req, 1);
    check({tag, "_c1_addr"}, imem_addr, 0);
    @(negedge clk);
    check({tag, "_c2_valid"}, instr_valid, 0);
    @(negedge clk);
    check({tag, "_c3_valid"}, instr_valid, 1);
    check({tag, "_c3_pc"}, instr_pc, 0);
  endtask

  task automatic wait_accept(input string tag, output logic [IAW-1:0] addr);
    bit found = 0;
    addr = '0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (imem_req && imem_ready) begin
        found = 1;
        addr  = imem_addr;
      end
    end
    if (!found) fail_now(tag, "no request accepted within 50 cycles");
  endtask

  task automatic wait_pc_end(input string tag, input int budget);
    for (int i = 0; i < budget && !pc_end; i++) @(negedge clk);
    check({tag, "_pc_end_reached"}, pc_end, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IAW-1:0] a;
    int             acc_cnt;
    int             pops_before;
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    sb_restart(10'h000);
    #2;
    check_reset_outputs("reset");

    // Startup, streaming to END and halting.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    startup_sequence("s1");
    wait_pc_end("s1", 50);
    @(negedge clk);
    check("s4_halt_req", imem_req, 0);
    check("s4_halt_valid", instr_valid, 0);

    // Redirect out of HALT with decode stalled: exactly QD accepts, then resume.
    instr_ready = 1'b0;
    step(); drive_redirect(10'h000);
    step(); redirect = 1'b0;
    @(negedge clk);
    check("s4_restart_pc_end", pc_end, 0);
    check("s4_restart_req", imem_req, 1);
    check("s4_restart_addr", imem_addr, 0);
    acc_cnt = (imem_req && imem_ready) ? 1 : 0;
    repeat (9) begin
      @(negedge clk);
      if (imem_req && imem_ready) acc_cnt++;
    end
    check("s2_accept_count", acc_cnt, QD);
    check("s2_req_blocked", imem_req, 0);
    check("s2_head_pc", instr_pc, 0);
    step(); instr_ready = 1'b1;
    wait_accept("s2_resume", a);
    check("s2_resume_addr", a, 10'h004);
    wait_pc_end("s2", 50);

    // Redirect with three queued entries and a response arriving the same cycle.
    instr_ready = 1'b0;
    step(); drive_redirect(10'h010);
    step(); redirect = 1'b0;
    repeat (4) step();
    drive_redirect(10'h040);
    @(negedge clk);
    check("s3_pre_valid", instr_valid, 1);
    check("s3_pre_pc", instr_pc, 10'h010);
    step(); redirect = 1'b0; instr_ready = 1'b1;
    @(negedge clk);
    check("s3_flushed_valid", instr_valid, 0);
    check("s3_req", imem_req, 1);
    check("s3_addr", imem_addr, 10'h040);
    repeat (6) @(negedge clk);

    // Address wrap at the top of the space.
    step(); drive_redirect(10'h3FF);
    step(); redirect = 1'b0;
    @(negedge clk);
    check("s5_req", imem_req, 1);
    check("s5_addr", imem_addr, 10'h3FF);
    wait_accept("s5_wrap", a);
    check("s5_wrap_addr", a, 10'h000);
    wait_pc_end("s5", 50);

    // Asynchronous reset mid-stream with a nearly full queue and a request in flight.
    instr_ready = 1'b0;
    step(); drive_redirect(10'h100);
    step(); redirect = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    instr_ready = 1'b1;
    sb_restart(10'h000);
    #1;
    check_reset_outputs("s6_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    startup_sequence("s6");
    wait_pc_end("s6", 50);

    // Random traffic: stalls on both sides and random redirects.
    rand_mem    = 1;
    pops_before = pops;
    for (int i = 0; i < 3000; i++) begin
      step();
      instr_ready = ($urandom_range(0, 3) != 0);
      if (redirect) redirect = 1'b0;
      else if ($urandom_range(0, 39) == 0 || (pc_end && $urandom_range(0, 3) == 0)) begin
        case ($urandom_range(0, 3))
          0:       drive_redirect(IAW'($urandom_range(0, 7)));
          1:       drive_redirect(IAW'($urandom_range(10'h3F8, 10'h3FF)));
          default: drive_redirect(IAW'($urandom));
        endcase
      end
    end
    step();
    redirect = 1'b0; instr_ready = 1'b1; rand_mem = 0;
    check("random_liveness", (pops - pops_before) > 200, 1);

    // Drain: the stream must run through END and halt.
    for (int i = 0; i < 3000 && !(pc_end && exp_q.size() == 0); i++) @(negedge clk);
    check("drain_remaining", exp_q.size(), 0);
    check("drain_pc_end", pc_end, 1);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
